// File: rtl/cc_cfg_pkg.sv
// rtl/cc_cfg_pkg.sv - address map, constants and FSM type for the cache controller CFG slave
package cc_cfg_pkg;

    localparam logic [11:0] ADDR_VERSION  = 12'h000;
    localparam logic [11:0] ADDR_CTRL     = 12'h004;
    localparam logic [11:0] ADDR_STATUS   = 12'h008;
    localparam logic [11:0] ADDR_INT_STAT = 12'h00C;
    localparam logic [11:0] ADDR_INT_MASK = 12'h010;
    localparam logic [11:0] ADDR_CNT_BASE = 12'h100;

    localparam logic [15:0] VERSION_MAJOR = 16'h0002;

    localparam int CTRL_CACHE_EN_BIT = 0;
    localparam int CTRL_FLUSH_BIT    = 1;
    localparam int STATUS_BUSY_BIT   = 0;
    localparam int INT_W             = 4;
    localparam int MAX_CH            = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } fsm_t;

endpackage

// File: rtl/cc_cfg_sat_cnt.sv
// rtl/cc_cfg_sat_cnt.sv - saturating event counter with synchronous clear
module cc_cfg_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] q_o
);

    logic [CNT_W-1:0] q_q;
    logic [CNT_W-1:0] q_d;

    // Clear wins over a coincident increment.
    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (inc_i && (q_q != {CNT_W{1'b1}})) begin
            q_d = q_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/cc_cfg_regs.sv
// rtl/cc_cfg_regs.sv - APB3 CFG register file; CC_CFG_PERF_EN builds the HIT/MISS counters
module cc_cfg_regs
    import cc_cfg_pkg::*;
#(
    parameter int NUM_CH      = 1,
    parameter int CNT_W       = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic [11:0]       paddr_i,
    input  logic              pwrite_i,
    input  logic [31:0]       pwdata_i,
    output logic              pready_o,
    output logic [31:0]       prdata_o,
    output logic              pslverr_o,
    output logic              cache_en_o,
    output logic              flush_o,
    input  logic              busy_i,
    input  logic [3:0]        evt_i,
    input  logic [NUM_CH-1:0] hit_i,
    input  logic [NUM_CH-1:0] miss_i,
    output logic              irq_o
);

    fsm_t        state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [11:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;

    logic             cache_en_q, cache_en_d;
    logic             flush_q, flush_d;
    logic [INT_W-1:0] int_stat_q, int_stat_d;
    logic [INT_W-1:0] int_mask_q, int_mask_d;
    logic             irq_q;

    logic at_wait, xfer_done, wr_ok, err;
    logic is_version, is_ctrl, is_status, is_istat, is_imask, is_cnt, mapped;
    logic [31:0] rdata_mux, cnt_rdata;

    assign at_wait   = (wcnt_q == 4'(WAIT_CYCLES));
    assign pready_o  = (state_q == ACCESS) && psel_i && penable_i && at_wait;
    assign xfer_done = pready_o;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (psel_i && !penable_i) begin
                    state_d = ACCESS;
                    addr_d  = paddr_i;
                    write_d = pwrite_i;
                    wdata_d = pwdata_i;
                    wcnt_d  = '0;
                end
            end
            ACCESS: begin
                if (!psel_i || xfer_done) begin
                    state_d = IDLE;
                end else if (!at_wait) begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign is_version = (addr_q[11:2] == ADDR_VERSION[11:2]);
    assign is_ctrl    = (addr_q[11:2] == ADDR_CTRL[11:2]);
    assign is_status  = (addr_q[11:2] == ADDR_STATUS[11:2]);
    assign is_istat   = (addr_q[11:2] == ADDR_INT_STAT[11:2]);
    assign is_imask   = (addr_q[11:2] == ADDR_INT_MASK[11:2]);
    assign mapped     = is_version | is_ctrl | is_status | is_istat | is_imask | is_cnt;
    assign err        = (addr_q[1:0] != 2'b00) | !mapped | (write_q & (is_version | is_status));
    assign wr_ok      = xfer_done & write_q & !err;

`ifdef CC_CFG_PERF_EN
    logic [2:0]  cnt_idx;
    logic        cnt_miss;
    logic [31:0] hit_v  [MAX_CH];
    logic [31:0] miss_v [MAX_CH];

    // Counter window: 0x100 + 8*ch, HIT at +0 and MISS at +4.
    assign cnt_idx  = addr_q[5:3];
    assign cnt_miss = addr_q[2];
    assign is_cnt   = (addr_q[11:8] == ADDR_CNT_BASE[11:8]) && (addr_q[7:6] == 2'b00)
                      && (int'(cnt_idx) < NUM_CH);

    for (genvar i = 0; i < MAX_CH; i++) begin : g_ch
        if (i < NUM_CH) begin : g_on
            logic [CNT_W-1:0] hit_cnt, miss_cnt;
            cc_cfg_sat_cnt #(.CNT_W(CNT_W)) u_hit (
                .clk   (clk),
                .rst_n (rst_n),
                .inc_i (hit_i[i]),
                .clr_i (wr_ok && is_cnt && (cnt_idx == 3'(i)) && !cnt_miss),
                .q_o   (hit_cnt)
            );
            cc_cfg_sat_cnt #(.CNT_W(CNT_W)) u_miss (
                .clk   (clk),
                .rst_n (rst_n),
                .inc_i (miss_i[i]),
                .clr_i (wr_ok && is_cnt && (cnt_idx == 3'(i)) && cnt_miss),
                .q_o   (miss_cnt)
            );
            assign hit_v[i]  = 32'(hit_cnt);
            assign miss_v[i] = 32'(miss_cnt);
        end else begin : g_off
            assign hit_v[i]  = '0;
            assign miss_v[i] = '0;
        end
    end

    assign cnt_rdata = cnt_miss ? miss_v[cnt_idx] : hit_v[cnt_idx];

    logic unused_w;
    assign unused_w = ^wdata_q[31:INT_W];
`else
    assign is_cnt    = 1'b0;
    assign cnt_rdata = '0;

    logic unused_w;
    assign unused_w = ^{wdata_q[31:INT_W], hit_i, miss_i};
`endif

    always_comb begin
        rdata_mux = '0;
        if (is_version) rdata_mux = {VERSION_MAJOR, 8'(NUM_CH), 8'(CNT_W)};
        if (is_ctrl)    rdata_mux[CTRL_CACHE_EN_BIT] = cache_en_q;
        if (is_status)  rdata_mux[STATUS_BUSY_BIT] = busy_i;
        if (is_istat)   rdata_mux[INT_W-1:0] = int_stat_q;
        if (is_imask)   rdata_mux[INT_W-1:0] = int_mask_q;
        if (is_cnt)     rdata_mux = cnt_rdata;
    end

    assign prdata_o  = (xfer_done && !write_q && !err) ? rdata_mux : 32'h0;
    assign pslverr_o = xfer_done & err;

    // New events take priority over a same-cycle W1C of the same bit.
    always_comb begin
        cache_en_d = cache_en_q;
        int_mask_d = int_mask_q;
        int_stat_d = int_stat_q;
        flush_d    = wr_ok && is_ctrl && wdata_q[CTRL_FLUSH_BIT];
        if (wr_ok && is_ctrl)  cache_en_d = wdata_q[CTRL_CACHE_EN_BIT];
        if (wr_ok && is_imask) int_mask_d = wdata_q[INT_W-1:0];
        if (wr_ok && is_istat) int_stat_d = int_stat_q & ~wdata_q[INT_W-1:0];
        int_stat_d = int_stat_d | evt_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wcnt_q     <= '0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            cache_en_q <= 1'b0;
            flush_q    <= 1'b0;
            int_stat_q <= '0;
            int_mask_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            cache_en_q <= cache_en_d;
            flush_q    <= flush_d;
            int_stat_q <= int_stat_d;
            int_mask_q <= int_mask_d;
            irq_q      <= |(int_stat_q & int_mask_q);
        end
    end

    assign cache_en_o = cache_en_q;
    assign flush_o    = flush_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_cc_cfg_regs.sv
// tb/tb_cc_cfg_regs.sv - scoreboard bench for cc_cfg_regs (NUM_CH=2, CNT_W=8, WAIT_CYCLES=3)
module tb_cc_cfg_regs;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 8;
    localparam int WAITS  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [11:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic        pready, pslverr, cache_en, flush, irq;
    logic [31:0] prdata;
    logic        busy = 1'b0;
    logic [3:0]  evt = '0;
    logic [NUM_CH-1:0] hit = '0, miss = '0;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_rdata_q [$];
    logic        exp_err_q   [$];
    logic        exp_chk_q   [$];
    string       name_q      [$];

    cc_cfg_regs #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .WAIT_CYCLES(WAITS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .psel_i     (psel),
        .penable_i  (penable),
        .paddr_i    (paddr),
        .pwrite_i   (pwrite),
        .pwdata_i   (pwdata),
        .pready_o   (pready),
        .prdata_o   (prdata),
        .pslverr_o  (pslverr),
        .cache_en_o (cache_en),
        .flush_o    (flush),
        .busy_i     (busy),
        .evt_i      (evt),
        .hit_i      (hit),
        .miss_i     (miss),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completed transfer is matched against the oldest expectation.
    always @(negedge clk) begin
        if (psel && penable && pready) begin
            if (exp_err_q.size() == 0) begin
                chk("unexpected_completion", 32'd1, 32'd0);
            end else begin
                automatic logic [31:0] er = exp_rdata_q.pop_front();
                automatic logic        ee = exp_err_q.pop_front();
                automatic logic        ec = exp_chk_q.pop_front();
                automatic string       nm = name_q.pop_front();
                chk({nm, "_pslverr"}, 32'(pslverr), 32'(ee));
                if (ec) chk({nm, "_prdata"}, prdata, er);
            end
        end
    end

    // One APB transfer; evt_d/hit_d are driven only during the completion cycle.
    task automatic apb(input string name, input logic [11:0] a, input logic w,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee,
                       input logic [3:0] evt_d, input logic [NUM_CH-1:0] hit_d,
                       output int waits);
        bit done = 0;
        exp_rdata_q.push_back(er);
        exp_err_q.push_back(ee);
        exp_chk_q.push_back(!w);
        name_q.push_back(name);
        waits = 0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (pready) begin
                done = 1;
                evt = evt_d;
                hit = hit_d;
            end else begin
                waits++;
            end
        end
        if (!done) chk({name, "_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; evt = '0; hit = '0;
    endtask

    task automatic rd(input string name, input logic [11:0] a, input logic [31:0] er, input logic ee);
        int w;
        apb(name, a, 1'b0, 32'h0, er, ee, 4'h0, '0, w);
    endtask

    task automatic wr(input string name, input logic [11:0] a, input logic [31:0] wd, input logic ee);
        int w;
        apb(name, a, 1'b1, wd, 32'h0, ee, 4'h0, '0, w);
    endtask

    initial begin
        int w;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_pready", 32'(pready), 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_outs", {28'd0, pslverr, cache_en, flush, irq}, 32'd0);

        rd("version", 12'h000, 32'h0002_0208, 1'b0);

        // CTRL write with wait states, then flush pulse and cache_en.
        apb("ctrl_wr", 12'h004, 1'b1, 32'h3, 32'h0, 1'b0, 4'h0, '0, w);
        chk("ctrl_wr_waits", 32'(w), 32'd3);
        @(negedge clk);
        chk("flush_hi", 32'(flush), 32'd1);
        chk("cache_en_hi", 32'(cache_en), 32'd1);
        @(negedge clk);
        chk("flush_lo", 32'(flush), 32'd0);
        rd("ctrl_rd", 12'h004, 32'h1, 1'b0);

        busy = 1'b1;
        rd("status_rd", 12'h008, 32'h1, 1'b0);
        busy = 1'b0;
        wr("status_wr", 12'h008, 32'h1, 1'b1);
        rd("misaligned", 12'h00A, 32'h0, 1'b1);
        rd("unmapped", 12'h200, 32'h0, 1'b1);

        // Interrupts.
        wr("imask_wr", 12'h010, 32'h1, 1'b0);
        rd("imask_rd", 12'h010, 32'h1, 1'b0);
        @(posedge clk); #1 evt = 4'b0001;
        @(posedge clk); #1 evt = 4'b0000;
        @(negedge clk);
        chk("irq_latency", 32'(irq), 32'd0);
        @(negedge clk);
        chk("irq_set", 32'(irq), 32'd1);
        rd("istat_rd", 12'h00C, 32'h1, 1'b0);
        apb("istat_w1c_evt", 12'h00C, 1'b1, 32'h1, 32'h0, 1'b0, 4'b0001, '0, w);
        rd("istat_set_wins", 12'h00C, 32'h1, 1'b0);
        wr("istat_w1c", 12'h00C, 32'h1, 1'b0);
        rd("istat_cleared", 12'h00C, 32'h0, 1'b0);
        @(negedge clk);
        chk("irq_clr", 32'(irq), 32'd0);

        // Abort a CTRL write during the access phase.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = 12'h004; pwrite = 1'b1; pwdata = 32'h0;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("abort_cache_en", 32'(cache_en), 32'd1);
        apb("abort_ctrl_rd", 12'h004, 1'b0, 32'h0, 32'h1, 1'b0, 4'h0, '0, w);
        chk("abort_idle_waits", 32'(w), 32'd3);

`ifdef CC_CFG_PERF_EN
        @(posedge clk); #1;
        for (int i = 0; i < 300; i++) begin
            hit = 2'b10;
            miss = (i < 5) ? 2'b01 : 2'b00;
            @(posedge clk); #1;
        end
        hit = '0; miss = '0;
        rd("hit1_sat", 12'h108, 32'h0000_00FF, 1'b0);
        rd("miss0", 12'h104, 32'h5, 1'b0);
        rd("hit0", 12'h100, 32'h0, 1'b0);
        apb("hit1_clr", 12'h108, 1'b1, 32'h0, 32'h0, 1'b0, 4'h0, 2'b10, w);
        rd("hit1_cleared", 12'h108, 32'h0, 1'b0);
        rd("ch2_unmapped", 12'h110, 32'h0, 1'b1);
`else
        @(posedge clk); #1 hit = 2'b11; miss = 2'b11;
        @(posedge clk); #1 hit = '0; miss = '0;
        rd("cnt_unbuilt", 12'h100, 32'h0, 1'b1);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_err_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
